// File: rtl/ps2_keyboard_rx_if.sv
// Key-event bus from the PS/2 receiver to its consumer.
// ps2_key: event word, rx_err: error pulse, busy: frame in progress.
interface ps2_keyboard_rx_if;
  logic [10:0] ps2_key;
  logic        rx_err;
  logic        busy;

  modport master (
    output ps2_key,
    output rx_err,
    output busy
  );

  modport slave (
    input ps2_key,
    input rx_err,
    input busy
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver plus make/break/E0/E1 scancode decoder.
// Ports: clk, reset_n (sync, active-low), raw ps2_clk/ps2_data,
// kbd (master): ps2_key[10]=toggle [9]=make [8]=E0 [7:0]=code,
// rx_err error pulse, busy while a frame is open.
// Optional: define PS2_TYPEMATIC_FILTER_EN to drop typematic repeats.
module ps2_keyboard_rx #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 28000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_keyboard_rx_if.master kbd
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;
  logic          noise;
  logic          emit;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0]  held_q, held_d;
  logic [8:0]    idx;
`endif

  // Synchronisers idle high, matching the released bus
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Level flips only after FILT_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = '0;
    if (state_q != S_IDLE && !fall_q) begin
      tmo_d = tmo_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (fall_q && !dat_s2_q) begin
          state_d = S_DATA;
          cnt_d   = 4'd1;
        end
      end
      S_DATA: begin
        if (fall_q) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (fall_q) begin
          par_d   = dat_s2_q;
          cnt_d   = cnt_q + 4'd1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_q) begin
          if (dat_s2_q && (^{shift_q, par_q})) begin
            vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (state_q != S_IDLE && !fall_q &&
        tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // BAT, ack, resend, echo and overrun codes carry no key
  always_comb begin
    noise = 1'b0;
    unique case (shift_q)
      8'hAA, 8'hFA, 8'hFC, 8'hFE,
      8'hEE, 8'h00, 8'hFF: noise = 1'b1;
      default:             noise = 1'b0;
    endcase
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    key_d  = key_q;
    emit   = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
    held_d = held_q;
    idx    = {ext_q, shift_q};
    emit   = brk_q | ~held_q[idx];
`endif
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (vld_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        unique case (1'b1)
          (shift_q == 8'hE1): skip_d = 3'd7;
          (shift_q == 8'hE0): ext_d  = 1'b1;
          (shift_q == 8'hF0): brk_d  = 1'b1;
          (noise && !ext_q && !brk_q): ;
          default: begin
            if (emit) begin
              key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
            end
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_d[idx] = ~brk_q;
`endif
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      fall_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= 3'd0;
      key_q   <= 11'd0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      fall_q  <= fall_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      skip_q  <= skip_d;
      key_q   <= key_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end
`endif

  assign kbd.ps2_key = key_q;
  assign kbd.rx_err  = err_q;
  assign kbd.busy    = (cnt_q != 4'd0);

endmodule
